alu_result_serializer: RTL
==========================

// Module: alu_result_serializer
// PURPOSE
//  Downstream neighbour of the ALU: captures each registered ALU result (ALU_OUT qualified by
//  the one-cycle ALU_Valid pulse), buffers it, and emits it as a byte stream (LS byte first) on a
//  valid/ready interface feeding the TX path (UART TX / CDC FIFO). Decouples single-cycle ALU
//  results from a slow byte consumer; drops and flags results arriving when the buffer is full.
// PARAMETERS
//  OUT_WIDTH   16  width of ALU_OUT; must be an integer multiple of BYTE_WIDTH
//  BYTE_WIDTH   8  width of one TX byte
//  DEPTH        2  result buffer entries; power of 2, >= 2
// PORTS
//  CLK         in   1          system clock; all logic on rising edge
//  RST         in   1          synchronous, active-high reset
//  ALU_OUT     in   OUT_WIDTH  ALU result; sampled only when ALU_Valid=1
//  ALU_Valid   in   1          result strobe from ALU (one cycle per result)
//  TX_DATA     out  BYTE_WIDTH byte to consumer
//  TX_VALID    out  1          TX_DATA valid
//  TX_READY    in   1          consumer accepts byte when TX_VALID & TX_READY at a rising edge
//  Ovf_Clr     in   1          clears Overflow
//  Overflow    out  1          sticky: a result was dropped
//  Busy        out  1          1 while buffer non-empty or a word is being sent
// BEHAVIOUR
//  - Reset (RST=1 at edge): TX_DATA=0, TX_VALID=0, Overflow=0, Busy=0, buffer empty, FSM=IDLE,
//    byte counter=0; any partially sent word is discarded. RST overrides all other inputs.
//  - NBYTES = OUT_WIDTH/BYTE_WIDTH. Byte k of a word = ALU_OUT[k*BYTE_WIDTH +: BYTE_WIDTH], k=0 first.
//  - Push: ALU_Valid=1 and (buffer not full, or a pop occurs same cycle) -> word written.
//    ALU_Valid=1 and full with no pop -> word dropped, Overflow<=1 next edge.
//  - Ovf_Clr=1 -> Overflow<=0; if a drop occurs in the same cycle, set wins (Overflow<=1).
//  - FSM (registered outputs, no combinational path from TX_READY to TX_VALID/TX_DATA):
//    IDLE: buffer non-empty -> pop head into shift reg, TX_DATA<=byte0, TX_VALID<=1, cnt<=0, ->SEND.
//    SEND: TX_READY=0 -> hold TX_DATA/TX_VALID stable.
//          TX_READY=1, cnt<NBYTES-1 -> shift, TX_DATA<=next byte, cnt<=cnt+1, stay SEND.
//          TX_READY=1, cnt=NBYTES-1 -> if buffer non-empty pop next word, TX_DATA<=its byte0,
//            cnt<=0, stay SEND (back-to-back, no bubble); else TX_VALID<=0, ->IDLE.
//  - Latency: ALU_Valid sampled at edge n into empty idle block -> TX_VALID=1 after edge n+1.
//  - Empty buffer + push same cycle: no bypass; word becomes visible next cycle.
//  - Throughput: one byte per cycle while TX_READY=1; sustained ALU rate <= 1 result per NBYTES cycles.
//  - Busy = (buffer non-empty) | (FSM != IDLE), registered-derived, no dependency on ALU_Valid.
//  - TX_DATA is 0 whenever TX_VALID=0 after returning to IDLE.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, SEND), NBYTES and byte-counter width localparams
//    ($clog2(NBYTES), min 1), buffer pointer width $clog2(DEPTH).
//  - One sub-module: result_fifo (synchronous FIFO, DEPTH x OUT_WIDTH, full/empty, simultaneous
//    push+pop when full permitted, pointers with extra wrap bit). Top holds FSM, shift reg, flags.
// TESTING
//  1. Reset: drive RST=1 mid-send of 0xBEEF after byte 0xEF accepted -> all outputs 0, 0xBE never sent.
//  2. Single result: ALU_OUT=0x1234 pulse, TX_READY=1 -> bytes 0x34 then 0x12 on consecutive
//     cycles, TX_VALID first high 2 edges after strobe, Busy falls after last byte.
//  3. Backpressure: TX_READY toggles 0/1 randomly while sending 0xA55A -> TX_DATA held stable while
//     TX_READY=0; exactly 0x5A,0xA5 delivered in order.
//  4. Overflow: TX_READY=0, three pulses 0x0001,0x0002,0x0003 (DEPTH=2) -> first popped into shift reg,
//     0x0002,0x0003 buffered; 4th pulse 0x0004 dropped, Overflow=1; release READY -> 01 00 02 00 03 00.
//  5. Full + pop same cycle: buffer full, ALU_Valid coincides with last-byte handshake -> new word
//     accepted, Overflow stays 0; Ovf_Clr and drop same cycle -> Overflow remains 1.
//  6. Back-to-back: results every 2 cycles with TX_READY=1 -> continuous TX_VALID, no bubbles, no drops.

Source files
------------

// File: rtl/alu_result_serializer_pkg.sv
// Shared types and sizing helpers for the ALU result serializer.
// Default geometry lives here; the top re-derives sizes from its own parameters.
package alu_result_serializer_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    localparam int unsigned OUT_WIDTH_DEF  = 16;
    localparam int unsigned BYTE_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 2;

    // Counter width that never collapses to zero bits for a single-byte word.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NBYTES = OUT_WIDTH_DEF / BYTE_WIDTH_DEF;
    localparam int unsigned CNT_W  = width_min1(NBYTES);
    localparam int unsigned PTR_W  = $clog2(DEPTH_DEF);

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// Synchronous result FIFO; pointers carry an extra wrap bit to tell full from empty.
// A push while full is accepted when a pop happens on the same edge.
module result_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers strobed ALU results and streams them out LS byte first on a valid/ready port.
// All TX outputs are registered so TX_READY never reaches TX_VALID/TX_DATA combinationally.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_Valid,
    output logic [BYTE_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    input  logic                  Ovf_Clr,
    output logic                  Overflow,
    output logic                  Busy
);
    localparam int unsigned NBytes = OUT_WIDTH / BYTE_WIDTH;
    localparam int unsigned CntW   = width_min1(NBytes);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  shift_q, shift_d;
    logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OUT_WIDTH-1:0]  fifo_rdata;
    logic                  drop;

    // A full buffer still takes a new word if the FSM drains one on the same edge.
    assign fifo_push = ALU_Valid && (!fifo_full || fifo_pop);
    assign drop      = ALU_Valid && fifo_full && !fifo_pop;

    result_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (ALU_OUT),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
                    tx_data_d  = fifo_rdata[BYTE_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (TX_READY) begin
                    if (cnt_q != LastCnt) begin
                        shift_d   = shift_q >> BYTE_WIDTH;
                        tx_data_d = shift_d[BYTE_WIDTH-1:0];
                        cnt_d     = cnt_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word without a bubble.
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        tx_data_d = fifo_rdata[BYTE_WIDTH-1:0];
                        cnt_d     = '0;
                    end else begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (Ovf_Clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign Overflow = ovf_q;
    assign Busy     = !fifo_empty || (state_q != StIdle);

endmodule
